// File: rtl/mfp_uart_pkg.sv
// mfp_uart_pkg: shared state encoding, oversampling constants and baud divider helper
package mfp_uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int SMP_A = 7;
    localparam int SMP_B = 8;
    localparam int SMP_C = 9;
    function automatic int tick_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate * 8) / (baud_rate * 16);
    endfunction
endpackage

// File: rtl/mfp_uart_rx_oversampled_if.sv
// mfp_uart_rx_oversampled_if: serial line in, byte stream and status out
interface mfp_uart_rx_oversampled_if;
    logic       rx;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       framing_error;
    logic       parity_error;
    logic       busy;
    modport master(input rx, output byte_data, byte_ready, framing_error, parity_error, busy);
    modport slave(output rx, input byte_data, byte_ready, framing_error, parity_error, busy);
endinterface

// File: rtl/mfp_uart_tick_gen.sv
// mfp_uart_tick_gen: oversample tick divider, held at zero while clear is high
module mfp_uart_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(TICK_DIV - 1);
    // count 0..TICK_DIV-1, restart after each tick
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mfp_uart_rx_oversampled.sv
// mfp_uart_rx_oversampled: 16x oversampled UART receiver, 3-sample majority vote; define MFP_UART_RX_PARITY_EN for even parity
module mfp_uart_rx_oversampled
    import mfp_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int TICK_DIV  = tick_div(CLK_FREQ, BAUD_RATE)
) (
    input logic clock,
    input logic reset,
    mfp_uart_rx_oversampled_if.master uart
);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    state_t     state, state_next;
    logic       rx_meta, rx_sync, rx_prev;
    logic       tick, dec, last, maj, fall;
    logic [3:0] sc;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       s_a, s_b;
    logic       good_stop, bad_stop;
    logic [7:0] byte_data;
    logic       byte_ready, framing_error;
`ifdef MFP_UART_RX_PARITY_EN
    logic       par_bit, par_err, parity_error;
`endif

    // two-flop synchronizer plus previous value for edge detection; idle-high reset
    always_ff @(posedge clock or posedge reset)
        if (reset) {rx_meta, rx_sync, rx_prev} <= 3'b111;
        else {rx_meta, rx_sync, rx_prev} <= {uart.rx, rx_meta, rx_sync};

    mfp_uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(state == IDLE),
        .tick (tick)
    );

    assign fall = rx_prev & ~rx_sync;
    assign dec  = tick && sc == 4'(SMP_C);
    assign last = tick && sc == LAST;
    assign maj  = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

    // state register
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;

    // next-state: stop decision returns to IDLE early so back-to-back frames are caught
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = fall ? START : IDLE;
            START:   state_next = (dec && maj) ? IDLE : last ? DATA : START;
`ifdef MFP_UART_RX_PARITY_EN
            DATA:    state_next = (last && bit_idx == 3'd7) ? PARITY : DATA;
            PARITY:  state_next = last ? STOP : PARITY;
`else
            DATA:    state_next = (last && bit_idx == 3'd7) ? STOP : DATA;
`endif
            STOP:    state_next = dec ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    // stop-bit outcome and busy flag
    always_comb begin
        uart.busy = state != IDLE;
        good_stop = state == STOP && dec && maj;
        bad_stop  = state == STOP && dec && !maj;
`ifdef MFP_UART_RX_PARITY_EN
        par_err   = (^shift) != par_bit;
`endif
    end

    // sample counter, vote samples, shift register and bit index
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            sc      <= '0;
            s_a     <= 1'b1;
            s_b     <= 1'b1;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            sc      <= (state == IDLE) ? '0 : tick ? sc + 1'b1 : sc;
            s_a     <= (tick && sc == 4'(SMP_A)) ? rx_sync : s_a;
            s_b     <= (tick && sc == 4'(SMP_B)) ? rx_sync : s_b;
            bit_idx <= (state == IDLE) ? '0 : (state == DATA && last) ? bit_idx + 1'b1 : bit_idx;
            shift   <= (state == DATA && dec) ? {maj, shift[7:1]} : shift;
        end

`ifdef MFP_UART_RX_PARITY_EN
    // received parity bit
    always_ff @(posedge clock or posedge reset)
        if (reset) par_bit <= 1'b0;
        else par_bit <= (state == PARITY && dec) ? maj : par_bit;

    // registered result pulses and held byte
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            byte_data     <= '0;
            byte_ready    <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            byte_data     <= (good_stop && !par_err) ? shift : byte_data;
            byte_ready    <= good_stop && !par_err;
            framing_error <= bad_stop;
            parity_error  <= good_stop && par_err;
        end

    assign uart.parity_error = parity_error;
`else
    // registered result pulses and held byte
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            byte_data     <= '0;
            byte_ready    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_data     <= good_stop ? shift : byte_data;
            byte_ready    <= good_stop;
            framing_error <= bad_stop;
        end

    assign uart.parity_error = 1'b0;
`endif

    assign uart.byte_data     = byte_data;
    assign uart.byte_ready    = byte_ready;
    assign uart.framing_error = framing_error;
endmodule
